// File: rtl/ram16k_ctrl.sv
// ram16k_ctrl: valid/ready request front end and clear engine for a 16K x 16 RAM
module ram16k_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);
  typedef enum logic [2:0] {CLEAR, IDLE, WR, RD, RESP} state_t;
  localparam state_t INIT = CLEAR_ON_RESET ? CLEAR : IDLE;
  localparam logic [ADDR_W:0] LAST = {1'b1, {ADDR_W{1'b0}}};
  state_t state, nxt;
  logic [ADDR_W:0] cnt;
  logic accept;
  assign req_ready = rst_n && state == IDLE && !clear_start;
  assign accept = req_valid && req_ready;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= nxt;
  // next-state: clear beats a coincident request; response waits for consumer
  always_comb begin
    nxt = state;
    case (state)
      CLEAR: nxt = cnt == LAST ? IDLE : CLEAR;
      IDLE:  nxt = clear_start ? CLEAR : accept ? (req_write ? WR : RD) : IDLE;
      WR:    nxt = IDLE;
      RD:    nxt = RESP;
      RESP:  nxt = rsp_ready ? IDLE : RESP;
      default: nxt = INIT;
    endcase
  end
  // registered RAM pins, clear counter and response channel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ram_load <= 1'b0;
      ram_address <= '0;
      ram_in <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy <= CLEAR_ON_RESET;
    end else begin
      cnt <= state == CLEAR ? cnt + 1'b1 : '0;
      ram_load <= nxt == WR || (state == CLEAR && cnt != LAST);
      ram_address <= state == CLEAR ? cnt[ADDR_W-1:0] : accept ? req_addr : ram_address;
      ram_in <= state == CLEAR ? CLEAR_VALUE : accept ? req_wdata : ram_in;
      rsp_valid <= state == RD || (state == RESP && !rsp_ready);
      rsp_rdata <= state == RD ? ram_out : rsp_rdata;
      busy <= nxt == CLEAR;
    end
endmodule
